branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC, immediate and target width.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit history counters; power of two, at least 4.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  reset, asynchronous, active-high.
REQ-005 valid_in  input  1  resolve request present this cycle.
REQ-006 stall_in  input  1  downstream stall; hold all output registers.
REQ-007 kill_in  input  1  squash the request and output stage (pipeline flush from a later stage).
REQ-008 pc_in  input  XLEN  PC of the resolving instruction.
REQ-009 imm_in  input  XLEN  sign-extended immediate.
REQ-010 rs1_in, rs2_in  input  XLEN  source operands.
REQ-011 opcode_6_to_2_in  input  5  opcode bits [6:2].
REQ-012 funct3_in  input  3  branch condition code.
REQ-013 pred_taken_in  input  1  fetch-time taken prediction.
REQ-014 pred_target_in  input  XLEN  fetch-time predicted next PC.
REQ-015 lookup_pc_in  input  XLEN  fetch PC for BHT prediction.
REQ-016 lookup_taken_out  output  1  predicted taken for lookup_pc_in (combinational).
REQ-017 valid_out  output  1  registered result valid.
REQ-018 branch_taken_out  output  1  registered resolved taken.
REQ-019 next_pc_out  output  XLEN  registered resolved next PC.
REQ-020 mispredict_out  output  1  registered misprediction; qualified by valid_out.

Function
REQ-021 Latency SHALL be exactly one cycle: a request accepted at edge N appears on the outputs after edge N.
REQ-022 JAL (11011): taken; next PC = pc_in+imm_in.
REQ-023 JALR (11001): taken; next PC = (rs1_in+imm_in) with bit 0 cleared.
REQ-024 Branch (11000): funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 not taken.
REQ-025 Branch next PC: pc_in+imm_in if taken, else pc_in+4.
REQ-026 Any other opcode: not taken, next PC pc_in+4, mispredict 0.
REQ-027 All additions SHALL be modulo 2^XLEN (wrap-around, no overflow flag).
REQ-028 Mispredict = (taken != pred_taken_in) OR (taken AND next PC != pred_target_in), for JAL/JALR/Branch only.
REQ-029 Priority kill_in > stall_in > valid_in: kill clears valid_out next cycle; stall holds every output register; otherwise valid_out <= valid_in.
REQ-030 Output registers other than valid_out SHALL load only when a request is accepted (valid_in, no stall, no kill).

Reset
REQ-031 Asynchronous reset SHALL clear valid_out, branch_taken_out, mispredict_out and next_pc_out to 0.
REQ-032 Reset SHALL set every BHT counter to 01 (weakly not-taken).
REQ-033 Reset mid-operation SHALL discard the in-flight result; no BHT update for it.

Configuration
REQ-034 Macro BRANCH_RESOLVE_BHT_EN defined: BHT present.
REQ-035 BHT index = pc[log2(BHT_DEPTH)+1:2]; lookup_taken_out = counter bit 1.
REQ-036 BHT update on each accepted Branch (11000) request only: increment if taken, decrement if not; saturate at 11 and 00.
REQ-037 Killed or stalled requests SHALL not update the BHT.
REQ-038 A lookup and an update to the same index in one cycle SHALL return the pre-update value.
REQ-039 Macro undefined: no counter storage; lookup_taken_out tied 0; all other behaviour unchanged.

Structure
REQ-040 Shared package branch_pkg SHALL hold the opcode constants JAL, JALR and BRANCH, the funct3 codes, the 2-bit counter type and its reset value 01.
REQ-041 The BHT SHALL be a sub-module branch_bht, instantiated only under BRANCH_RESOLVE_BHT_EN.

Verification
REQ-042 BEQ: rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle taken=1, next_pc=0x120, mispredict=1.
REQ-043 BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken with next_pc=pc+4.
REQ-044 JALR: rs1=0x1001, imm=2, pred_taken=1, pred_target=0x1002 -> next_pc=0x1002, mispredict=0.
REQ-045 Stall: valid_in and stall_in high for 3 cycles -> outputs frozen; kill_in together with stall_in -> valid_out=0.
REQ-046 BHT (macro on): 3 taken branches at pc=0x40 -> lookup 0x40 gives 0,1,1; counter saturates at 11; 4 not-taken -> 0.
REQ-047 pc=0xFFFFFFFC, not-taken branch -> next_pc wraps to 0x00000000.

Source files
------------

// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit and its history table:
//   - major opcode values (instruction bits [6:2]) for JAL, JALR and BRANCH
//   - funct3 condition codes for conditional branches
//   - the 2-bit saturating history counter type, its reset value and the
//     saturating update helper
// ---------------------------------------------------------------------------
package branch_pkg;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] BRANCH = 5'b11000;

    // Branch condition codes (funct3). 010 and 011 are not valid branch
    // conditions and resolve as not taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating history counter; bit 1 is the taken prediction.
    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken
    localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

    // Saturating step: move toward 11 on taken, toward 00 on not taken.
    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                result = ctr + 2'b01;
            end
        end else begin
            if (ctr != 2'b00) begin
                result = ctr - 2'b01;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// ---------------------------------------------------------------------------
// branch_bht
// Branch history table of BHT_DEPTH 2-bit saturating counters.
//
// Ports:
//   clk_in            clock, counters update on its rising edge
//   reset_in          asynchronous active-high reset, all counters -> 01
//   lookup_idx_in     table index for the fetch-side prediction
//   lookup_taken_out  combinational prediction (counter bit 1)
//   update_en_in      train the counter at update_idx_in this cycle
//   update_idx_in     table index of the resolving branch
//   update_taken_in   resolved direction used for training
//
// The lookup reads the registered counters directly, so a lookup and an
// update to the same index in one cycle always sees the pre-update value.
// ---------------------------------------------------------------------------
module branch_bht
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [IDX_W-1:0] lookup_idx_in,
    output logic             lookup_taken_out,
    input  logic             update_en_in,
    input  logic [IDX_W-1:0] update_idx_in,
    input  logic             update_taken_in
);

    bht_ctr_t ctr_q [BHT_DEPTH];

    // Counter storage: every entry returns to weakly not-taken on reset, and
    // only the single entry addressed by an accepted branch is trained.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_CTR_RESET;
            end
        end else if (update_en_in) begin
            ctr_q[update_idx_in] <= bht_ctr_next(ctr_q[update_idx_in], update_taken_in);
        end
    end

    // Prediction is the counter's upper bit
    assign lookup_taken_out = ctr_q[lookup_idx_in][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves JAL, JALR and conditional branches one cycle after acceptance,
// producing the actual direction, the actual next PC and a misprediction
// flag against the fetch-time prediction. Optionally hosts a branch history
// table that predicts direction for the fetch PC.
//
// Configuration macro: BRANCH_RESOLVE_BHT_EN
//   defined   -> branch_bht instantiated, trained by accepted branches
//   undefined -> no history storage, lookup_taken_out tied to 0
//
// Ports:
//   clk_in, reset_in        clock and asynchronous active-high reset
//   valid_in                resolve request present
//   stall_in                hold every output register
//   kill_in                 squash request and output stage
//   pc_in, imm_in           instruction PC and sign-extended immediate
//   rs1_in, rs2_in          source operands
//   opcode_6_to_2_in        opcode bits [6:2]
//   funct3_in               branch condition code
//   pred_taken_in           fetch-time taken prediction
//   pred_target_in          fetch-time predicted next PC
//   lookup_pc_in            fetch PC for the history table prediction
//   lookup_taken_out        combinational history prediction
//   valid_out               registered result valid
//   branch_taken_out        registered resolved direction
//   next_pc_out             registered resolved next PC
//   mispredict_out          registered misprediction, qualified by valid_out
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            valid_in,
    input  logic            stall_in,
    input  logic            kill_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      opcode_6_to_2_in,
    input  logic [2:0]      funct3_in,
    input  logic            pred_taken_in,
    input  logic [XLEN-1:0] pred_target_in,
    input  logic [XLEN-1:0] lookup_pc_in,
    output logic            lookup_taken_out,
    output logic            valid_out,
    output logic            branch_taken_out,
    output logic [XLEN-1:0] next_pc_out,
    output logic            mispredict_out
);

    // All sums wrap naturally at XLEN bits
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;

    assign seq_pc      = pc_in + XLEN'(4);
    assign pc_plus_imm = pc_in + imm_in;
    assign jalr_sum    = rs1_in + imm_in;
    assign jalr_target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};

    logic            res_taken;
    logic [XLEN-1:0] res_next_pc;
    logic            res_is_cti;
    logic            res_mispredict;
    logic            accept;

    // Resolve direction and next PC. res_is_cti marks control-transfer
    // instructions; anything else falls through to pc+4 and can never
    // report a misprediction.
    always_comb begin
        res_taken   = 1'b0;
        res_next_pc = seq_pc;
        res_is_cti  = 1'b0;
        case (opcode_6_to_2_in)
            JAL: begin
                res_is_cti  = 1'b1;
                res_taken   = 1'b1;
                res_next_pc = pc_plus_imm;
            end
            JALR: begin
                res_is_cti  = 1'b1;
                res_taken   = 1'b1;
                res_next_pc = jalr_target;
            end
            BRANCH: begin
                res_is_cti = 1'b1;
                case (funct3_in)
                    F3_BEQ:  res_taken = (rs1_in == rs2_in);
                    F3_BNE:  res_taken = (rs1_in != rs2_in);
                    F3_BLT:  res_taken = ($signed(rs1_in) <  $signed(rs2_in));
                    F3_BGE:  res_taken = ($signed(rs1_in) >= $signed(rs2_in));
                    F3_BLTU: res_taken = (rs1_in <  rs2_in);
                    F3_BGEU: res_taken = (rs1_in >= rs2_in);
                    default: res_taken = 1'b0;
                endcase
                res_next_pc = res_taken ? pc_plus_imm : seq_pc;
            end
            default: begin
                res_taken   = 1'b0;
                res_next_pc = seq_pc;
                res_is_cti  = 1'b0;
            end
        endcase
    end

    // A wrong direction always mispredicts; a correct taken prediction still
    // mispredicts if the predicted target was wrong.
    assign res_mispredict = res_is_cti &
                            ((res_taken != pred_taken_in) |
                             (res_taken & (res_next_pc != pred_target_in)));

    assign accept = valid_in & ~stall_in & ~kill_in;

    // Valid bit: kill wins over stall, stall freezes, otherwise it follows
    // the incoming request.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_out <= 1'b0;
        end else if (kill_in) begin
            valid_out <= 1'b0;
        end else if (!stall_in) begin
            valid_out <= valid_in;
        end
    end

    // Result registers only change on an accepted request, so a dropped
    // valid or a kill leaves the last resolved result visible.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            branch_taken_out <= 1'b0;
            next_pc_out      <= '0;
            mispredict_out   <= 1'b0;
        end else if (accept) begin
            branch_taken_out <= res_taken;
            next_pc_out      <= res_next_pc;
            mispredict_out   <= res_mispredict;
        end
    end

`ifdef BRANCH_RESOLVE_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic             bht_update;
    logic             unused_lookup_bits;

    // Word-aligned PCs: the byte offset bits carry no history information
    assign lookup_idx = lookup_pc_in[IDX_W+1:2];
    assign update_idx = pc_in[IDX_W+1:2];
    assign unused_lookup_bits = ^{lookup_pc_in[XLEN-1:IDX_W+2], lookup_pc_in[1:0]};

    // Only conditional branches train the table; jumps are always taken and
    // would just pollute the counters.
    assign bht_update = accept & (opcode_6_to_2_in == BRANCH);

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .lookup_idx_in    (lookup_idx),
        .lookup_taken_out (lookup_taken_out),
        .update_en_in     (bht_update),
        .update_idx_in    (update_idx),
        .update_taken_in  (res_taken)
    );
`else
    logic unused_bht;

    assign unused_bht       = ^{lookup_pc_in, BHT_CTR_RESET, 32'(BHT_DEPTH)};
    assign lookup_taken_out = 1'b0;
`endif

endmodule
